regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with write-through bypass, optional hardwired zero register
// and a per-register busy scoreboard for read-after-write hazard detection.
module regfile_sb #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addrR,
    input  logic [WIDTH-1:0]  dataR,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    output logic [WIDTH-1:0]  dataA,
    output logic [WIDTH-1:0]  dataB,
    output logic              busyA,
    output logic              busyB,
    output logic              hazard
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wr_en;
    logic iss_en;

    logic zero_a;
    logic zero_b;
    logic fwd_a;
    logic fwd_b;

    // Writes and issues aimed at a hardwired zero register are dropped.
    always_comb begin
        wr_en  = we;
        iss_en = issue;
        if (ZERO_REG != 0) begin
            if (addrR == '0) begin
                wr_en = 1'b0;
            end
            if (issue_addr == '0) begin
                iss_en = 1'b0;
            end
        end
    end

    // Issue is applied after the write clear so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[addrR] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[addrR] <= dataR;
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        zero_a = (ZERO_REG != 0) && (addrA == '0);
        zero_b = (ZERO_REG != 0) && (addrB == '0);
        fwd_a  = (BYPASS != 0) && we && (addrR == addrA);
        fwd_b  = (BYPASS != 0) && we && (addrR == addrB);
    end

    // Busy depends only on we/addrR/addrX, never on dataR.
    always_comb begin
        dataA = mem_q[addrA];
        busyA = busy_q[addrA];
        if (zero_a) begin
            dataA = '0;
            busyA = 1'b0;
        end else if (fwd_a) begin
            dataA = dataR;
            busyA = 1'b0;
        end

        dataB = mem_q[addrB];
        busyB = busy_q[addrB];
        if (zero_b) begin
            dataB = '0;
            busyB = 1'b0;
        end else if (fwd_b) begin
            dataB = dataR;
            busyB = 1'b0;
        end

        hazard = busyA | busyB;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass/no zero reg, and zero reg/no bypass)
// share stimulus; a reference model pushes expected outputs to a scoreboard queue.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  addrR;
    logic [15:0] dataR;
    logic        issue;
    logic [2:0]  issue_addr;
    logic [2:0]  addrA;
    logic [2:0]  addrB;

    logic [15:0] data_a [2];
    logic [15:0] data_b [2];
    logic        busy_a [2];
    logic        busy_b [2];
    logic        haz    [2];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] da;
        logic [15:0] db;
        logic        ba;
        logic        bb;
        logic        hz;
    } exp_t;

    exp_t exp_q[$];

    // Reference state; index 0: ZERO_REG=0/BYPASS=1, index 1: ZERO_REG=1/BYPASS=0.
    logic [15:0] m_mem  [2][8];
    logic        m_busy [2][8];
    bit          cfg_zero [2] = '{1'b0, 1'b1};
    bit          cfg_byp  [2] = '{1'b1, 1'b0};

    regfile_sb #(
        .WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)
    ) u_dut_byp (
        .clk(clk), .reset(reset), .we(we), .addrR(addrR), .dataR(dataR),
        .issue(issue), .issue_addr(issue_addr), .addrA(addrA), .addrB(addrB),
        .dataA(data_a[0]), .dataB(data_b[0]), .busyA(busy_a[0]), .busyB(busy_b[0]),
        .hazard(haz[0])
    );

    regfile_sb #(
        .WIDTH(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)
    ) u_dut_zero (
        .clk(clk), .reset(reset), .we(we), .addrR(addrR), .dataR(dataR),
        .issue(issue), .issue_addr(issue_addr), .addrA(addrA), .addrB(addrB),
        .dataA(data_a[1]), .dataB(data_b[1]), .busyA(busy_a[1]), .busyB(busy_b[1]),
        .hazard(haz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mdl_data(input int d, input logic [2:0] a);
        if (cfg_zero[d] && a == 3'd0) return 16'h0;
        if (cfg_byp[d] && we && addrR == a) return dataR;
        return m_mem[d][a];
    endfunction

    function automatic logic mdl_busy(input int d, input logic [2:0] a);
        if (cfg_zero[d] && a == 3'd0) return 1'b0;
        if (cfg_byp[d] && we && addrR == a) return 1'b0;
        return m_busy[d][a];
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    m_mem[d][i]  = 16'h0;
                    m_busy[d][i] = 1'b0;
                end
            end else begin
                if (we && !(cfg_zero[d] && addrR == 3'd0)) begin
                    m_mem[d][addrR]  = dataR;
                    m_busy[d][addrR] = 1'b0;
                end
                if (issue && !(cfg_zero[d] && issue_addr == 3'd0)) begin
                    m_busy[d][issue_addr] = 1'b1;
                end
            end
        end
    endtask

    // Push expectations for current inputs, compare at negedge, then advance one edge.
    task automatic step();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e.da = mdl_data(d, addrA);
            e.db = mdl_data(d, addrB);
            e.ba = mdl_busy(d, addrA);
            e.bb = mdl_busy(d, addrB);
            e.hz = e.ba | e.bb;
            exp_q.push_back(e);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e = exp_q.pop_front();
            check_eq($sformatf("sb%0d_dataA", d), {16'h0, data_a[d]}, {16'h0, e.da});
            check_eq($sformatf("sb%0d_dataB", d), {16'h0, data_b[d]}, {16'h0, e.db});
            check_eq($sformatf("sb%0d_busyA", d), {31'h0, busy_a[d]}, {31'h0, e.ba});
            check_eq($sformatf("sb%0d_busyB", d), {31'h0, busy_b[d]}, {31'h0, e.bb});
            check_eq($sformatf("sb%0d_hazard", d), {31'h0, haz[d]}, {31'h0, e.hz});
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        we    = 1'b0;
        issue = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[d][i]  = 16'h0;
                m_busy[d][i] = 1'b0;
            end
        end
        reset = 1'b1; we = 1'b0; issue = 1'b0;
        addrR = 3'd0; dataR = 16'h0; issue_addr = 3'd0; addrA = 3'd0; addrB = 3'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset sweep of all registers.
        for (int i = 0; i < 8; i++) begin
            addrA = 3'(i);
            addrB = 3'(7 - i);
            step();
        end

        // Write then read, same-cycle bypass vs. no bypass.
        we = 1'b1; addrR = 3'd5; dataR = 16'hBEEF; addrA = 3'd5; addrB = 3'd1;
        #1;
        check_eq("wr_same_byp", {16'h0, data_a[0]}, 32'h0000BEEF);
        check_eq("wr_same_nobyp", {16'h0, data_a[1]}, 32'h0);
        step();
        idle_inputs();
        #1;
        check_eq("wr_next_byp", {16'h0, data_a[0]}, 32'h0000BEEF);
        check_eq("wr_next_nobyp", {16'h0, data_a[1]}, 32'h0000BEEF);
        step();

        // RAW hazard on register 3.
        issue = 1'b1; issue_addr = 3'd3; addrA = 3'd3;
        step();
        idle_inputs();
        #1;
        check_eq("raw_busy", {31'h0, busy_a[0]}, 32'h1);
        check_eq("raw_hazard", {31'h0, haz[0]}, 32'h1);
        step();
        step();
        we = 1'b1; addrR = 3'd3; dataR = 16'h1234;
        #1;
        check_eq("raw_clr_busy", {31'h0, busy_a[0]}, 32'h0);
        check_eq("raw_clr_data", {16'h0, data_a[0]}, 32'h00001234);
        step();
        idle_inputs();
        step();

        // Simultaneous issue and write to the same register.
        issue = 1'b1; issue_addr = 3'd2; we = 1'b1; addrR = 3'd2; dataR = 16'h00AA; addrB = 3'd2;
        step();
        idle_inputs();
        #1;
        check_eq("iw_dataB", {16'h0, data_b[0]}, 32'h000000AA);
        check_eq("iw_busyB", {31'h0, busy_b[0]}, 32'h1);
        step();

        // Register 0: hardwired in the zero-reg instance, ordinary in the other.
        we = 1'b1; addrR = 3'd0; dataR = 16'hFFFF; issue = 1'b1; issue_addr = 3'd0; addrA = 3'd0;
        step();
        idle_inputs();
        #1;
        check_eq("zero_dataA", {16'h0, data_a[1]}, 32'h0);
        check_eq("zero_busyA", {31'h0, busy_a[1]}, 32'h0);
        check_eq("r0_dataA", {16'h0, data_a[0]}, 32'h0000FFFF);
        step();

        // Reset mid-operation discards busy bits and data.
        issue = 1'b1; issue_addr = 3'd1;
        step();
        issue_addr = 3'd7;
        step();
        issue_addr = 3'd4; we = 1'b1; addrR = 3'd4; dataR = 16'h5555;
        step();
        idle_inputs();
        addrA = 3'd4; addrB = 3'd7;
        #1;
        check_eq("pre_rst_busy", {31'h0, busy_a[0]}, 32'h1);
        step();
        reset = 1'b1; we = 1'b1; addrR = 3'd4; dataR = 16'h9999;
        step();
        idle_inputs();
        #1;
        check_eq("post_rst_data", {16'h0, data_a[0]}, 32'h0);
        check_eq("post_rst_hazard", {31'h0, haz[0]}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            addrA = 3'(i);
            addrB = 3'((i + 3) % 8);
            step();
        end

        // Random traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            we         = 1'($urandom_range(0, 1));
            issue      = 1'($urandom_range(0, 1));
            addrR      = 3'($urandom_range(0, 7));
            issue_addr = 3'($urandom_range(0, 7));
            addrA      = 3'($urandom_range(0, 7));
            addrB      = ($urandom_range(0, 3) == 0) ? addrA : 3'($urandom_range(0, 7));
            dataR      = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
